vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): CLK_DIV 2 clk cycles per pixel; H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 horizontal timing in pixels; V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 vertical timing in lines; SYNC_POL 0 sync asserted level; COLOR_W 4 bits per colour; NUM_LAYERS 3 draw layers.
REQ-002 Derived: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters; CW = 11 bits for counters and coordinates.
REQ-003 Ports (name, direction, width, meaning): clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-004 layer_draw in NUM_LAYERS, per-layer pixel-covered flag for the current pix_x/pix_y.
REQ-005 layer_rgb in NUM_LAYERS*3*COLOR_W, per-layer {R,G,B}; layer i occupies slice i.
REQ-006 bg_rgb in 3*COLOR_W, background colour inside the active area.
REQ-007 pix_x, pix_y out CW each, stage-0 coordinates; pix_tick out 1, pixel strobe.
REQ-008 line_start, frame_start out 1 each, single-clk pulses.
REQ-009 hsync, vsync out 1 each; video_active out 1; red, green, blue out COLOR_W each.

Function
REQ-010 Divider counts 0..CLK_DIV-1 and wraps; pix_tick is high for exactly one clk when the count equals CLK_DIV-1. CLK_DIV=1 gives pix_tick constantly high.
REQ-011 hcnt and vcnt advance only on clk edges where pix_tick=1.
REQ-012 hcnt counts 0..H_TOTAL-1, then wraps to 0.
REQ-013 vcnt increments when hcnt wraps, and wraps to 0 after V_TOTAL-1.
REQ-014 pix_x = hcnt and pix_y = vcnt (stage 0).
REQ-015 Stage-0 active = (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE).
REQ-016 Stage-0 hsync asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-017 Stage-0 vsync asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-018 An asserted sync drives level SYNC_POL; a deasserted sync drives the inverse of SYNC_POL.
REQ-019 line_start = pix_tick and hcnt=0.
REQ-020 frame_start = pix_tick and hcnt=0 and vcnt=0.
REQ-021 Stage 1, on pix_tick: register layer_draw, layer_rgb, bg_rgb and the stage-0 active/hsync/vsync.
REQ-022 Stage 2, on pix_tick: colour = the layer_rgb of the lowest-index layer with stage-1 draw=1; if no layer draws, colour = bg_rgb; if stage-1 active=0, colour = 0. Register the colour together with stage-1 active/hsync/vsync.
REQ-023 red/green/blue, hsync, vsync and video_active are driven from stage 2. They lag pix_x/pix_y by exactly 2 pixel ticks and are mutually aligned.
REQ-024 All outputs change only on pix_tick edges, except the divider-derived strobes (pix_tick, line_start, frame_start).
REQ-025 layer_draw and layer_rgb are sampled only on pix_tick edges; changes between ticks have no effect.
REQ-026 Parameters are not checked; H_TOTAL must be at most 2^CW and CLK_DIV at least 1.

Reset
REQ-027 While reset=1 at a clk edge: divider, hcnt and vcnt = 0.
REQ-028 Same edge: both pipeline stages cleared to active=0 and sync deasserted.
REQ-029 Same edge: red/green/blue = 0, hsync = vsync = the inverse of SYNC_POL, video_active = 0.
REQ-030 Reset asserted mid-frame takes effect on the same edge regardless of pix_tick.
REQ-031 After reset deasserts, the first pix_tick occurs CLK_DIV-1 clks later, and frame_start occurs on that tick.

Verification
REQ-032 Defaults, reset then run 840000 clks -> exactly one frame: 525 line_start pulses, 800 pix_tick per line, frame_start period 840000 clks.
REQ-033 Defaults -> hsync low for 96 ticks beginning 2 ticks after pix_x=656. vsync low for 2 lines, for vcnt 490-491 delayed by 2 ticks.
REQ-034 layer_draw=3'b110, layer1=F00, layer2=0F0, bg=00F at pix_x=5 -> red=F, green=0, blue=0 two ticks later. layer_draw=0 -> colour 00F.
REQ-035 All layers drawing at pix_x=640 (blanking) -> colour 000 and video_active=0 two ticks later. At pix_x=639 -> layer0 colour and video_active=1.
REQ-036 SYNC_POL=1, CLK_DIV=1, small timing (H 8/1/2/1, V 4/1/1/1) -> H_TOTAL 12, V_TOTAL 7. Syncs are high only in their windows and frame_start occurs every 84 clks.
REQ-037 Reset asserted at hcnt=300, vcnt=200 -> next edge: hcnt=vcnt=0, rgb=0, syncs deasserted. After release, the first tick restarts from (0,0) with frame_start.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video port bundle: per-layer draw requests flow into the timing generator,
// and pixel coordinates, strobes, syncs and colour flow out of it.
interface vga_timing_gen_if #(
    parameter int COLOR_W    = 4,
    parameter int NUM_LAYERS = 3,
    parameter int CW         = 11
);
    logic [NUM_LAYERS-1:0]            layer_draw;
    logic [NUM_LAYERS*3*COLOR_W-1:0]  layer_rgb;
    logic [3*COLOR_W-1:0]             bg_rgb;
    logic [CW-1:0]                    pix_x;
    logic [CW-1:0]                    pix_y;
    logic                             pix_tick;
    logic                             line_start;
    logic                             frame_start;
    logic                             hsync;
    logic                             vsync;
    logic                             video_active;
    logic [COLOR_W-1:0]               red;
    logic [COLOR_W-1:0]               green;
    logic [COLOR_W-1:0]               blue;

    modport master (
        input  layer_draw, layer_rgb, bg_rgb,
        output pix_x, pix_y, pix_tick, line_start, frame_start,
               hsync, vsync, video_active, red, green, blue
    );

    modport slave (
        output layer_draw, layer_rgb, bg_rgb,
        input  pix_x, pix_y, pix_tick, line_start, frame_start,
               hsync, vsync, video_active, red, green, blue
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a two-stage layer compositor; syncs and
// colour come out of stage 2, two pixel ticks behind pix_x/pix_y.
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int NUM_LAYERS = 3
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int CW      = 11;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RGB_W   = 3 * COLOR_W;

    logic [DIV_W-1:0] div_reg;
    logic [CW-1:0]    hcnt_reg;
    logic [CW-1:0]    vcnt_reg;
    logic             pix_tick;

    // With CLK_DIV=1 the divider never leaves 0, so the strobe stays high.
    assign pix_tick = (div_reg == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg  <= '0;
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else begin
            div_reg <= pix_tick ? '0 : div_reg + 1'b1;
            if (pix_tick) begin
                if (hcnt_reg == CW'(H_TOTAL - 1)) begin
                    hcnt_reg <= '0;
                    vcnt_reg <= (vcnt_reg == CW'(V_TOTAL - 1)) ? '0 : vcnt_reg + 1'b1;
                end else begin
                    hcnt_reg <= hcnt_reg + 1'b1;
                end
            end
        end
    end

    logic act0;
    logic hs0;
    logic vs0;

    assign act0 = (hcnt_reg < CW'(H_ACTIVE)) && (vcnt_reg < CW'(V_ACTIVE));
    assign hs0  = (hcnt_reg >= CW'(H_ACTIVE + H_FP)) &&
                  (hcnt_reg <= CW'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign vs0  = (vcnt_reg >= CW'(V_ACTIVE + V_FP)) &&
                  (vcnt_reg <= CW'(V_ACTIVE + V_FP + V_SYNC - 1));

    logic [NUM_LAYERS-1:0]       s1_draw_reg;
    logic [NUM_LAYERS*RGB_W-1:0] s1_rgb_reg;
    logic [RGB_W-1:0]            s1_bg_reg;
    logic                        s1_act_reg;
    logic                        s1_hs_reg;
    logic                        s1_vs_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_draw_reg <= '0;
            s1_rgb_reg  <= '0;
            s1_bg_reg   <= '0;
            s1_act_reg  <= 1'b0;
            s1_hs_reg   <= 1'b0;
            s1_vs_reg   <= 1'b0;
        end else if (pix_tick) begin
            s1_draw_reg <= vga.layer_draw;
            s1_rgb_reg  <= vga.layer_rgb;
            s1_bg_reg   <= vga.bg_rgb;
            s1_act_reg  <= act0;
            s1_hs_reg   <= hs0;
            s1_vs_reg   <= vs0;
        end
    end

    logic [RGB_W-1:0] s1_layer [NUM_LAYERS];

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        assign s1_layer[gi] = s1_rgb_reg[gi*RGB_W +: RGB_W];
    end

    // Walk from the top layer down so the lowest drawing index wins.
    logic [RGB_W-1:0] rgb_next;

    always_comb begin
        rgb_next = s1_bg_reg;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_draw_reg[i]) begin
                rgb_next = s1_layer[i];
            end
        end
        if (!s1_act_reg) begin
            rgb_next = '0;
        end
    end

    logic [RGB_W-1:0] s2_rgb_reg;
    logic             s2_act_reg;
    logic             s2_hs_reg;
    logic             s2_vs_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_rgb_reg <= '0;
            s2_act_reg <= 1'b0;
            s2_hs_reg  <= 1'b0;
            s2_vs_reg  <= 1'b0;
        end else if (pix_tick) begin
            s2_rgb_reg <= rgb_next;
            s2_act_reg <= s1_act_reg;
            s2_hs_reg  <= s1_hs_reg;
            s2_vs_reg  <= s1_vs_reg;
        end
    end

    assign vga.pix_x        = hcnt_reg;
    assign vga.pix_y        = vcnt_reg;
    assign vga.pix_tick     = pix_tick;
    assign vga.line_start   = pix_tick && (hcnt_reg == '0);
    assign vga.frame_start  = pix_tick && (hcnt_reg == '0) && (vcnt_reg == '0);
    assign vga.hsync        = s2_hs_reg ? SYNC_POL : ~SYNC_POL;
    assign vga.vsync        = s2_vs_reg ? SYNC_POL : ~SYNC_POL;
    assign vga.video_active = s2_act_reg;
    assign vga.red          = s2_rgb_reg[3*COLOR_W-1 -: COLOR_W];
    assign vga.green        = s2_rgb_reg[2*COLOR_W-1 -: COLOR_W];
    assign vga.blue         = s2_rgb_reg[COLOR_W-1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: a default-timing instance and a tiny
// positive-sync instance, both checked every clk against a raster model.
module tb_vga_timing_gen;
    typedef struct {
        int div;
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit pol;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic [2:0]  draw  = '0;
    logic [35:0] lrgb  = '0;
    logic [11:0] bg    = '0;

    int checks = 0;
    int errors = 0;
    longint cur_cyc = 0;

    vga_timing_gen_if #(.COLOR_W(4), .NUM_LAYERS(3), .CW(11)) if_a ();
    vga_timing_gen_if #(.COLOR_W(4), .NUM_LAYERS(3), .CW(11)) if_b ();

    assign if_a.layer_draw = draw;
    assign if_a.layer_rgb  = lrgb;
    assign if_a.bg_rgb     = bg;
    assign if_b.layer_draw = draw;
    assign if_b.layer_rgb  = lrgb;
    assign if_b.bg_rgb     = bg;

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vga   (if_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .COLOR_W(4), .NUM_LAYERS(3)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vga   (if_b)
    );

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cur_cyc, got, exp);
        end
    endtask

    // Raster position after cyc clk edges since reset: one tick every div clks.
    function automatic logic [24:0] exp_pos(input cfg_t c, input longint cyc);
        int ht, vt, x, y;
        longint n;
        logic tick, ls, fs;
        ht   = c.ha + c.hfp + c.hsw + c.hbp;
        vt   = c.va + c.vfp + c.vsw + c.vbp;
        n    = cyc / c.div;
        x    = int'(n % ht);
        y    = int'((n / ht) % vt);
        tick = ((cyc % c.div) == longint'(c.div - 1));
        ls   = tick && (x == 0);
        fs   = ls && (y == 0);
        return {11'(x), 11'(y), tick, ls, fs};
    endfunction

    // {hsync_asserted, vsync_asserted, active, rgb} for one pixel position.
    function automatic logic [14:0] pixel_video(input cfg_t c, input int x, input int y,
                                                input logic [2:0] d, input logic [35:0] l,
                                                input logic [11:0] b);
        logic act, hs, vs;
        logic [11:0] rgb;
        act = (x < c.ha) && (y < c.va);
        hs  = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hsw);
        vs  = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vsw);
        rgb = b;
        for (int i = 2; i >= 0; i--) begin
            if (d[i]) rgb = l[i*12 +: 12];
        end
        if (!act) rgb = 12'h000;
        return {hs, vs, act, rgb};
    endfunction

    function automatic logic [24:0] obs_pos(input int sel);
        if (sel == 0)
            return {if_a.pix_x, if_a.pix_y, if_a.pix_tick, if_a.line_start, if_a.frame_start};
        return {if_b.pix_x, if_b.pix_y, if_b.pix_tick, if_b.line_start, if_b.frame_start};
    endfunction

    function automatic logic [14:0] obs_video(input int sel);
        if (sel == 0)
            return {if_a.hsync, if_a.vsync, if_a.video_active, if_a.red, if_a.green, if_a.blue};
        return {if_b.hsync, if_b.vsync, if_b.video_active, if_b.red, if_b.green, if_b.blue};
    endfunction

    task automatic run_phase(input int sel, input cfg_t c, input int ncyc,
                             input int rst_at, input int rst_odds, input string name);
        longint cyc;
        logic [14:0] hist[$];
        logic [14:0] v;
        logic [24:0] p;
        int rst_hold;
        bit rst_now;
        cyc = 0;
        rst_hold = 2;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            cur_cyc = cyc;
            if (k > 0) begin
                v = (hist.size() == 2) ? hist[0] : 15'h0000;
                v = {v[14] ? c.pol : ~c.pol, v[13] ? c.pol : ~c.pol, v[12:0]};
                check({name, "_pos"}, 40'(obs_pos(sel)), 40'(exp_pos(c, cyc)));
                check({name, "_video"}, 40'(obs_video(sel)), 40'(v));
            end
            if (k == rst_at || (rst_odds > 0 && $urandom_range(0, rst_odds - 1) == 0))
                rst_hold = int'($urandom_range(1, 3));
            rst_now = (rst_hold > 0);
            if (rst_hold > 0) rst_hold--;
            if (sel == 0) rst_a = rst_now;
            else          rst_b = rst_now;
            draw = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom());
            lrgb = 36'({$urandom(), $urandom()});
            bg   = 12'($urandom());
            if (rst_now) begin
                cyc = 0;
                hist.delete();
            end else begin
                p = exp_pos(c, cyc);
                if (p[2]) begin
                    hist.push_back(pixel_video(c, int'(p[24:14]), int'(p[13:3]), draw, lrgb, bg));
                    if (hist.size() > 2) void'(hist.pop_front());
                end
                cyc++;
            end
        end
        if (sel == 0) rst_a = 1'b1;
        else          rst_b = 1'b1;
    endtask

    initial begin
        cfg_t cfg_a;
        cfg_t cfg_b;
        cfg_a = '{div: 2, ha: 640, hfp: 16, hsw: 96, hbp: 48,
                  va: 480, vfp: 10, vsw: 2, vbp: 33, pol: 1'b0};
        cfg_b = '{div: 1, ha: 8, hfp: 1, hsw: 2, hbp: 1,
                  va: 4, vfp: 1, vsw: 1, vbp: 1, pol: 1'b1};
        repeat (3) @(negedge clk);
        // Default timing: several full lines, one mid-line reset.
        run_phase(0, cfg_a, 7000, 5100, 0, "dflt");
        // Tiny timing: many frames with sporadic mid-frame resets.
        run_phase(1, cfg_b, 4000, 1500, 700, "tiny");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
